drp_arbiter: RTL and testbench
==============================

# drp_arbiter

Round-robin arbiter that shares the single GTP common-block DRP port between several requesters, such as the PCIe core's QPLL DRP master and an MMR-side configuration agent. Requesters speak native DRP: a one-cycle enable, then a one-cycle ready with read data. The block serializes requests, keeps exactly one transaction outstanding on the shared port, and converts a missing `drp_rdy` into an error completion. It sits between the requesters and `gt_common_wrapper`, in the `PS_clk` domain, which is also the DRP clock.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, minimum 1, maximum 8.
- `TIMEOUT`, 255: cycles to wait for `drp_rdy` after `drp_en`; must be ≥ 2.

Ports:
- `aclk` in 1: single clock for all logic and the DRP port.
- `aresetn` in 1: reset, asynchronous and active-low.
- `req_en` in N_REQ: per-requester DRP enable, one-cycle pulse.
- `req_we` in N_REQ: write enable, qualified by `req_en`.
- `req_addr` in N_REQ×8: DRP address.
- `req_di` in N_REQ×16: write data.
- `req_do` out 16: read data, shared by all requesters, qualified by `req_rdy`.
- `req_rdy` out N_REQ: completion pulse, one-hot.
- `req_err` out 1: completion was a timeout, qualified by `req_rdy`.
- `req_ovf` out N_REQ: sticky flag; a request arrived while that requester already had one pending.
- `drp_en` out 1: to DRP.
- `drp_we` out 1: to DRP.
- `drp_addr` out 8: to DRP.
- `drp_di` out 16: to DRP.
- `drp_do` in 16: from DRP.
- `drp_rdy` in 1: from DRP.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- **Capture.** Each requester has one pending slot holding `we`, `addr` and `di`. `req_en[i]` with the slot empty loads the slot.
- **Overflow.** `req_en[i]` with the slot full discards the new request and sets `req_ovf[i]`. `req_ovf[i]` clears only on reset.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
  - IDLE → ISSUE when any slot is pending.
  - ISSUE → WAIT unconditionally.
  - WAIT → RESP on `drp_rdy` or on timeout.
  - RESP → IDLE unconditionally.
- **Arbitration** is round-robin and happens in IDLE. Search starts at (last granted + 1) mod N_REQ. The pointer resets to N_REQ−1, so requester 0 wins first.
- **ISSUE.**
  - `drp_en` is 1 for exactly this cycle.
  - `drp_we`, `drp_addr` and `drp_di` come from the granted slot.
  - The granted slot is freed at the end of ISSUE, so that requester may submit again.
- **WAIT.**
  - A counter runs from 1 after ISSUE.
  - `drp_do` is captured on `drp_rdy`.
  - When the counter reaches TIMEOUT with no `drp_rdy`: `req_do` = 16'hFFFF and the error flag is set.
  - A `drp_rdy` already present during ISSUE is accepted as if it arrived in WAIT.
- **RESP.**
  - `req_rdy[grant]` = 1 for one cycle.
  - `req_do` holds the captured data; for writes it is `drp_do` as sampled.
  - `req_err` is set for a timeout completion.
- **Stray ready.** `drp_rdy` in IDLE or RESP is ignored, e.g. a late reply after a timeout.
- **Slot write vs. grant.** A `req_en[i]` in the same cycle that slot i is freed counts as arriving to an empty slot: it is accepted, with no overflow.

## Timing
- **Reset values.**
  - `drp_en`, `drp_we`, `req_rdy`, `req_err`, `req_ovf`, `busy` = 0.
  - `drp_addr`, `drp_di`, `req_do` = 0.
  - Slots empty; FSM in IDLE; pointer = N_REQ−1.
- **Reset mid-transaction.** Everything returns to the reset state immediately. Pending requests are lost and no completion is issued.
- **Outputs are registered.** No combinational path from any input to any output.
- **Latency, idle block:**
  - `req_en` sampled at edge k → slot full after k.
  - FSM leaves IDLE at edge k+1 → `drp_en` high in cycle k+1..k+2.
  - `drp_rdy` sampled at edge m → `req_rdy` high in cycle m..m+1.
  - Minimum request-to-completion is 4 cycles.
- **Timeout completion:** `req_rdy` and `req_err` appear TIMEOUT+1 cycles after the `drp_en` cycle.
- **Throughput:** at most one DRP transaction per 4 cycles.

## Structure
- Package `drp_pkg`:
  - `DRP_AW` = 8, `DRP_DW` = 16.
  - `drp_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `drp_req_t` struct (`we`, `addr`, `di`).
  - `DRP_TIMEOUT_DATA` = 16'hFFFF.
- Sub-module `rr_arbiter` (N_REQ):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and index.
  - Purely combinational; the pointer is updated by `drp_arbiter` on ISSUE.

## Test plan
- **Single read:** req 0 reads 8'h11, model returns 16'hABCD 3 cycles after `drp_en` → `req_rdy[0]` one pulse, `req_do` = 16'hABCD, `req_err` = 0, `drp_en` a single-cycle pulse.
- **Collision:** req 0 and req 1 pulse `req_en` together after reset → requester 0 served first, then requester 1. Repeated simultaneous bursts alternate 1, 0, 1…; no starvation over 100 transactions.
- **Timeout:** model never asserts `drp_rdy`, TIMEOUT = 10 → completion 11 cycles after `drp_en`, `req_err` = 1, `req_do` = 16'hFFFF. A late `drp_rdy` 5 cycles later causes no completion.
- **Overflow:** req 1 pulses `req_en` twice before its grant → second request dropped, `req_ovf[1]` = 1 and stays 1. Only one DRP access occurs.
- **Reset mid-WAIT:** deassert `aresetn` during WAIT → all outputs 0 at once. After release, no completion is issued and a new request is served normally.
- **Write ordering:** scoreboard against a DRP memory model with random reads and writes from both requesters → every read returns the last write to that address in the issued order.

Source files
------------

// File: rtl/drp_arbiter_pkg.sv
// Shared types and constants for the DRP port arbiter.
package drp_pkg;

   localparam int DRP_AW = 8;
   localparam int DRP_DW = 16;

   localparam logic [DRP_DW-1:0] DRP_TIMEOUT_DATA = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } drp_state_t;

   typedef struct packed {
      logic              we;
      logic [DRP_AW-1:0] addr;
      logic [DRP_DW-1:0] di;
   } drp_req_t;

endpackage

// File: rtl/drp_arbiter_rr.sv
// Combinational round-robin pick: search starts one past the last granted requester.
module rr_arbiter #(
   parameter  int N_REQ = 2,
   localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx
);

   logic [IW-1:0] cand;

   // Walk from farthest to nearest so the nearest pending requester wins.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      cand = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = IW'((int'(ptr) + k) % N_REQ);
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/drp_arbiter.sv
// Shares one DRP port among N_REQ native-DRP requesters, one transaction in flight,
// with a timeout that turns a missing drp_rdy into an error completion.
//
// state | meaning
// IDLE  | no transaction; round-robin pick among pending slots
// ISSUE | drp_en high for this cycle; granted slot freed at its end
// WAIT  | waiting for drp_rdy or timer terminal count
// RESP  | req_rdy pulse to the granted requester
module drp_arbiter
   import drp_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [N_REQ-1:0]           req_en,
   input  logic [N_REQ-1:0]           req_we,
   input  logic [N_REQ*DRP_AW-1:0]    req_addr,
   input  logic [N_REQ*DRP_DW-1:0]    req_di,
   output logic [DRP_DW-1:0]          req_do,
   output logic [N_REQ-1:0]           req_rdy,
   output logic                       req_err,
   output logic [N_REQ-1:0]           req_ovf,
   output logic                       drp_en,
   output logic                       drp_we,
   output logic [DRP_AW-1:0]          drp_addr,
   output logic [DRP_DW-1:0]          drp_di,
   input  logic [DRP_DW-1:0]          drp_do,
   input  logic                       drp_rdy,
   output logic                       busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT);

   drp_state_t        state, state_nxt;
   drp_req_t          slot [N_REQ];
   logic [N_REQ-1:0]  slot_vld;
   logic [N_REQ-1:0]  slot_free;
   logic [N_REQ-1:0]  arb_gnt;
   logic [IW-1:0]     arb_idx;
   logic [IW-1:0]     gnt_idx;
   logic [IW-1:0]     ptr;
   drp_req_t          cur;
   logic [TW-1:0]     timer;
   logic              rdy_seen;
   logic              err_q;
   logic [DRP_DW-1:0] data_q;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr (
      .req (slot_vld),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|arb_gnt) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (rdy_seen || drp_rdy || timer == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      slot_free = '0;
      if (state == ISSUE) slot_free[gnt_idx] = 1'b1;
   end

   // A request landing in the cycle its slot is freed refills the slot cleanly.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         slot_vld <= '0;
         req_ovf  <= '0;
         for (int i = 0; i < N_REQ; i++) slot[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_en[i] && (!slot_vld[i] || slot_free[i])) begin
               slot_vld[i] <= 1'b1;
               slot[i]     <= '{we:   req_we[i],
                                addr: req_addr[i*DRP_AW +: DRP_AW],
                                di:   req_di[i*DRP_DW +: DRP_DW]};
            end else if (slot_free[i]) begin
               slot_vld[i] <= 1'b0;
            end
            if (req_en[i] && slot_vld[i] && !slot_free[i]) req_ovf[i] <= 1'b1;
         end
      end
   end

   // Timer is loaded in ISSUE and counts down; zero in WAIT is the timeout.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         gnt_idx  <= '0;
         ptr      <= IW'(N_REQ - 1);
         cur      <= '0;
         timer    <= '0;
         rdy_seen <= 1'b0;
         err_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|arb_gnt) begin
                  gnt_idx <= arb_idx;
                  cur     <= slot[arb_idx];
               end
            end
            ISSUE: begin
               ptr      <= gnt_idx;
               timer    <= TW'(TIMEOUT - 1);
               err_q    <= 1'b0;
               rdy_seen <= drp_rdy;
               if (drp_rdy) data_q <= drp_do;
            end
            WAIT: begin
               if (!rdy_seen) begin
                  if (drp_rdy) begin
                     data_q <= drp_do;
                  end else if (timer == '0) begin
                     data_q <= DRP_TIMEOUT_DATA;
                     err_q  <= 1'b1;
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy     = (state != IDLE);
      drp_en   = (state == ISSUE);
      drp_we   = (state == ISSUE) & cur.we;
      drp_addr = cur.addr;
      drp_di   = cur.di;
      req_do   = data_q;
      req_rdy  = '0;
      if (state == RESP) req_rdy[gnt_idx] = 1'b1;
      req_err  = (state == RESP) & err_q;
   end

endmodule

// File: tb/tb_drp_arbiter.sv
// Directed bench for drp_arbiter with a behavioural DRP memory responder.
module tb_drp_arbiter;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [1:0]  req_en;
   logic [1:0]  req_we;
   logic [15:0] req_addr;
   logic [31:0] req_di;
   logic [15:0] req_do;
   logic [1:0]  req_rdy;
   logic        req_err;
   logic [1:0]  req_ovf;
   logic        drp_en;
   logic        drp_we;
   logic [7:0]  drp_addr;
   logic [15:0] drp_di;
   logic [15:0] drp_do;
   logic        drp_rdy;
   logic        busy;

   int vectors = 0;
   int errs    = 0;

   always #5 aclk = ~aclk;

   drp_arbiter #(.N_REQ(2), .TIMEOUT(10)) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .req_en   (req_en),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_di   (req_di),
      .req_do   (req_do),
      .req_rdy  (req_rdy),
      .req_err  (req_err),
      .req_ovf  (req_ovf),
      .drp_en   (drp_en),
      .drp_we   (drp_we),
      .drp_addr (drp_addr),
      .drp_di   (drp_di),
      .drp_do   (drp_do),
      .drp_rdy  (drp_rdy),
      .busy     (busy)
   );

   // DRP responder: replies rsp_delay cycles after drp_en (0 = same cycle as drp_en).
   logic [15:0] mem [256] = '{8'h11: 16'hABCD, 8'h20: 16'h1111, 8'h21: 16'h2222, default: 16'h0000};
   bit          rsp_on    = 1'b1;
   int          rsp_delay = 3;
   int          rsp_cd    = 0;
   logic [7:0]  rsp_addr  = '0;
   int          stray_req = 0;
   int          stray_ack = 0;
   int          en_cnt    = 0;
   int          en_multi  = 0;
   int          rdy_cnt   = 0;
   logic        en_prev   = 1'b0;

   always @(negedge aclk) begin
      drp_rdy = 1'b0;
      if (stray_req != stray_ack) begin
         drp_rdy   = 1'b1;
         stray_ack = stray_req;
      end
      if (rsp_cd > 0) begin
         rsp_cd--;
         if (rsp_cd == 0) begin
            drp_rdy = 1'b1;
            drp_do  = mem[rsp_addr];
         end
      end
      if (drp_en && rsp_on) begin
         if (drp_we) mem[drp_addr] = drp_di;
         rsp_addr = drp_addr;
         if (rsp_delay == 0) begin
            drp_rdy = 1'b1;
            drp_do  = mem[drp_addr];
         end else begin
            rsp_cd = rsp_delay;
         end
      end
      if (drp_en) en_cnt++;
      if (drp_en && en_prev) en_multi++;
      en_prev = drp_en;
      if (|req_rdy) rdy_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
      req_en[i]          = 1'b1;
      req_we[i]          = we;
      req_addr[i*8 +: 8] = a;
      req_di[i*16 +: 16] = d;
      @(posedge aclk); #1;
      req_en = '0;
   endtask

   task automatic send2(input logic we0, input logic [7:0] a0, input logic [15:0] d0,
                        input logic we1, input logic [7:0] a1, input logic [15:0] d1);
      req_en   = 2'b11;
      req_we   = {we1, we0};
      req_addr = {a1, a0};
      req_di   = {d1, d0};
      @(posedge aclk); #1;
      req_en = '0;
   endtask

   task automatic wait_rdy(input int max, output int cyc, output logic [1:0] rv,
                           output logic [15:0] dv, output logic ev);
      cyc = 0; rv = '0; dv = '0; ev = 1'b0;
      for (int n = 1; n <= max; n++) begin
         @(posedge aclk); #1;
         if (|req_rdy) begin
            cyc = n; rv = req_rdy; dv = req_do; ev = req_err;
            break;
         end
      end
      if (cyc == 0) begin
         vectors++;
         errs++;
         $error("FAIL wait_rdy: no completion within %0d cycles", max);
      end
   endtask

   initial begin
      int          cyc;
      logic [1:0]  rv;
      logic [15:0] dv;
      logic        ev;
      int          en0, rdy0, r;
      logic [15:0] sb [4];
      logic [1:0]  we_v;
      logic [7:0]  a_v [2];
      logic [15:0] d_v [2];
      logic [1:0]  done;

      aresetn = 1'b0;
      req_en = '0; req_we = '0; req_addr = '0; req_di = '0;
      for (int i = 0; i < 4; i++) sb[i] = '0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_drp_en", drp_en, 1'b0);
      chk("rst_drp_we", drp_we, 1'b0);
      chk("rst_req_rdy", req_rdy, 2'b00);
      chk("rst_req_err", req_err, 1'b0);
      chk("rst_req_ovf", req_ovf, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_drp_addr", drp_addr, 8'h00);
      chk("rst_drp_di", drp_di, 16'h0000);
      chk("rst_req_do", req_do, 16'h0000);
      aresetn = 1'b1;
      @(posedge aclk); #1;

      // Collision right after reset, then repeated simultaneous bursts.
      for (int b = 0; b < 6; b++) begin
         send2(1'b0, 8'h20, 16'h0, 1'b0, 8'h21, 16'h0);
         wait_rdy(20, cyc, rv, dv, ev);
         chk("burst_first_rdy", rv, 2'b01);
         chk("burst_first_do", dv, 16'h1111);
         wait_rdy(20, cyc, rv, dv, ev);
         chk("burst_second_rdy", rv, 2'b10);
         chk("burst_second_do", dv, 16'h2222);
      end

      // Single read with a 3-cycle responder.
      @(posedge aclk); #1;
      en0 = en_cnt;
      send(0, 1'b0, 8'h11, 16'h0);
      chk("single_busy_pre", busy, 1'b0);
      @(posedge aclk); #1;
      chk("single_drp_en", drp_en, 1'b1);
      chk("single_drp_addr", drp_addr, 8'h11);
      chk("single_drp_we", drp_we, 1'b0);
      wait_rdy(20, cyc, rv, dv, ev);
      chk("single_latency", cyc, 4);
      chk("single_rdy", rv, 2'b01);
      chk("single_do", dv, 16'hABCD);
      chk("single_err", ev, 1'b0);
      @(posedge aclk); #1;
      chk("single_rdy_pulse", req_rdy, 2'b00);
      chk("single_busy_post", busy, 1'b0);
      chk("single_en_count", en_cnt - en0, 1);
      chk("single_en_width", en_multi, 0);

      // drp_rdy already present during ISSUE.
      rsp_delay = 0;
      send(0, 1'b0, 8'h11, 16'h0);
      wait_rdy(20, cyc, rv, dv, ev);
      chk("early_latency", cyc, 3);
      chk("early_do", dv, 16'hABCD);
      rsp_delay = 3;
      @(posedge aclk); #1;

      // Request arriving the cycle its slot is freed is accepted.
      en0 = en_cnt;
      send(0, 1'b0, 8'h20, 16'h0);
      @(posedge aclk); #1;
      send(0, 1'b0, 8'h21, 16'h0);
      chk("reuse_ovf", req_ovf, 2'b00);
      wait_rdy(20, cyc, rv, dv, ev);
      chk("reuse_first_rdy", rv, 2'b01);
      chk("reuse_first_do", dv, 16'h1111);
      wait_rdy(20, cyc, rv, dv, ev);
      chk("reuse_second_rdy", rv, 2'b01);
      chk("reuse_second_do", dv, 16'h2222);
      chk("reuse_en_count", en_cnt - en0, 2);
      @(posedge aclk); #1;

      // Overflow: requester 1 pulses twice while requester 0 holds the port.
      en0 = en_cnt;
      send(0, 1'b0, 8'h11, 16'h0);
      send(1, 1'b1, 8'h30, 16'h5555);
      send(1, 1'b1, 8'h31, 16'h6666);
      chk("ovf_set", req_ovf, 2'b10);
      wait_rdy(20, cyc, rv, dv, ev);
      chk("ovf_first_rdy", rv, 2'b01);
      wait_rdy(20, cyc, rv, dv, ev);
      chk("ovf_second_rdy", rv, 2'b10);
      repeat (4) @(posedge aclk);
      #1;
      chk("ovf_en_count", en_cnt - en0, 2);
      chk("ovf_mem_kept", mem[8'h30], 16'h5555);
      chk("ovf_mem_dropped", mem[8'h31], 16'h0000);
      chk("ovf_sticky", req_ovf, 2'b10);

      // Timeout with no reply, then a stray late drp_rdy.
      rsp_on = 1'b0;
      send(0, 1'b0, 8'h40, 16'h0);
      @(posedge aclk); #1;
      chk("to_drp_en", drp_en, 1'b1);
      wait_rdy(30, cyc, rv, dv, ev);
      chk("to_latency", cyc, 11);
      chk("to_rdy", rv, 2'b01);
      chk("to_err", ev, 1'b1);
      chk("to_do", dv, 16'hFFFF);
      repeat (5) @(posedge aclk);
      #1;
      rdy0 = rdy_cnt;
      stray_req++;
      repeat (10) @(posedge aclk);
      #1;
      chk("stray_no_rdy", rdy_cnt - rdy0, 0);
      chk("stray_busy", busy, 1'b0);

      // Reset in WAIT with another request pending.
      en0 = en_cnt;
      send(1, 1'b0, 8'h21, 16'h0);
      send(0, 1'b0, 8'h20, 16'h0);
      @(posedge aclk); #1;
      chk("midrst_wait_busy", busy, 1'b1);
      chk("midrst_wait_en", drp_en, 1'b0);
      aresetn = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ovf", req_ovf, 2'b00);
      chk("midrst_req_do", req_do, 16'h0000);
      chk("midrst_drp_addr", drp_addr, 8'h00);
      chk("midrst_req_rdy", req_rdy, 2'b00);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      rsp_on  = 1'b1;
      rdy0 = rdy_cnt;
      repeat (10) @(posedge aclk);
      #1;
      chk("midrst_no_rdy", rdy_cnt - rdy0, 0);
      chk("midrst_no_access", en_cnt - en0, 1);
      send(1, 1'b0, 8'h21, 16'h0);
      wait_rdy(20, cyc, rv, dv, ev);
      chk("midrst_new_rdy", rv, 2'b10);
      chk("midrst_new_do", dv, 16'h2222);
      @(posedge aclk); #1;

      // Random read/write pairs from both requesters against a scoreboard.
      for (int t = 0; t < 30; t++) begin
         rsp_delay = $urandom_range(0, 4);
         for (int i = 0; i < 2; i++) begin
            we_v[i] = 1'($urandom_range(0, 1));
            a_v[i]  = 8'h80 + 8'($urandom_range(0, 3));
            d_v[i]  = 16'($urandom);
         end
         send2(we_v[0], a_v[0], d_v[0], we_v[1], a_v[1], d_v[1]);
         done = '0;
         for (int j = 0; j < 2; j++) begin
            wait_rdy(20, cyc, rv, dv, ev);
            if (rv == 2'b01 || rv == 2'b10) begin
               r = rv[1] ? 1 : 0;
               chk("sb_dup", done[r], 1'b0);
               done[r] = 1'b1;
               chk("sb_err", ev, 1'b0);
               if (we_v[r]) sb[a_v[r][1:0]] = d_v[r];
               else chk("sb_read", dv, sb[a_v[r][1:0]]);
            end else begin
               chk("sb_onehot", rv, 2'b01);
            end
         end
      end
      chk("final_en_width", en_multi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
